pe_array_sequencer: RTL and testbench

- Synthesizable initiator for parallel_pe; replaces the bench-side stimulus logic with real control.
- Walks an instruction buffer where each 8-bit entry is a dot-product length in beats.
- Issues neuron and weight SRAM reads, drives pe_vld/pe_ctl to parallel_pe, and collects each pe_result into a result buffer.
- Sits between the on-chip neuron/weight/instruction SRAMs and parallel_pe.

---
 rtl/pe_seq_pkg.sv | 17 +
 rtl/pe_result_collector.sv | 60 ++++++
 rtl/pe_array_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_pe_array_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE array sequencer.
package pe_seq_pkg;

  localparam int INST_LEN_W = 8;
  localparam int CTL_FIRST  = 0;
  localparam int CTL_LAST   = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    ISSUE,
    DRAIN,
    FINISH
  } seqState_e;

endpackage

// File: rtl/pe_result_collector.sv
// Captures parallel_pe results into the result buffer. It numbers them in
// arrival order and flags any result that arrives when none is expected.
module pe_result_collector
  import pe_seq_pkg::*;
#(
  parameter int INST_AW = 2,
  parameter int RES_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_active,
  input  logic [INST_AW:0]   i_expected,
  input  logic [RES_W-1:0]   i_result,
  input  logic               i_resultVld,
  output logic               o_resWr,
  output logic [INST_AW-1:0] o_resAddr,
  output logic [RES_W-1:0]   o_resData,
  output logic [INST_AW:0]   o_count,
  output logic               o_overflow
);

  logic [INST_AW:0]   r_count;
  logic               r_resWr;
  logic [INST_AW-1:0] r_resAddr;
  logic [RES_W-1:0]   r_resData;
  logic               w_accept;

  // Accept a result only inside a run and only while results are still owed
  always_comb begin
    w_accept   = i_resultVld && i_active && (r_count < i_expected);
    o_overflow = i_resultVld && !w_accept;
  end

  // Register the buffer write and advance the result count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_resWr   <= 1'b0;
      r_resAddr <= '0;
      r_resData <= '0;
    end else if (i_clear) begin
      r_count   <= '0;
      r_resWr   <= 1'b0;
    end else begin
      r_resWr <= w_accept;
      if (w_accept) begin
        r_resAddr <= r_count[INST_AW-1:0];
        r_resData <= i_result;
        r_count   <= r_count + 1'b1;
      end
    end
  end

  assign o_resWr   = r_resWr;
  assign o_resAddr = r_resAddr;
  assign o_resData = r_resData;
  assign o_count   = r_count;

endmodule

// File: rtl/pe_array_sequencer.sv
// Initiator for parallel_pe. It walks the instruction buffer, streams
// neuron/weight beats and collects one result per nonzero instruction.
// Optional macro SEQ_INST_PREFETCH_EN: fetches the next instruction during
// ISSUE so that consecutive instructions stream without a bubble.
module pe_array_sequencer
  import pe_seq_pkg::*;
#(
  parameter int INST_AW = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 512,
  parameter int RES_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [INST_AW:0]      inst_num,
  output logic [INST_AW-1:0]    inst_addr,
  input  logic [INST_LEN_W-1:0] inst_data,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     neuron_i,
  input  logic [DATA_W-1:0]     weight_i,
  output logic [DATA_W-1:0]     pe_neuron,
  output logic [DATA_W-1:0]     pe_weight,
  output logic [1:0]            pe_ctl,
  output logic                  pe_vld,
  input  logic [RES_W-1:0]      pe_result,
  input  logic                  pe_vld_o,
  output logic                  res_wr,
  output logic [INST_AW-1:0]    res_addr,
  output logic [RES_W-1:0]      res_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  seqState_e             r_state;
  seqState_e             w_nextState;
  logic [INST_AW:0]      r_num;
  logic [INST_AW:0]      r_idx;
  logic [INST_AW:0]      r_expCnt;
  logic [INST_LEN_W-1:0] r_len;
  logic [INST_LEN_W-1:0] r_beat;
  logic [ADDR_W-1:0]     r_memAddr;
  logic                  r_err;
  logic                  r_peVld;
  logic [1:0]            r_peCtl;

  logic                  w_startAcc;
  logic                  w_lastBeat;
  logic                  w_lastInst;
  logic                  w_zeroLen;
  logic                  w_setErr;
  logic                  w_overflow;
  logic [INST_AW:0]      w_resCount;
  logic [INST_AW:0]      w_idxPlus1;
  logic [INST_AW-1:0]    w_instAddr;
`ifdef SEQ_INST_PREFETCH_EN
  logic [INST_AW:0]      w_idxPlus2;
  logic                  w_skipLast;
`endif

  assign w_startAcc = (r_state == IDLE) && start;
  assign w_lastBeat = (r_beat == r_len - 1'b1);
  assign w_idxPlus1 = r_idx + 1'b1;
  assign w_lastInst = (w_idxPlus1 == r_num);
  assign w_zeroLen  = (inst_data == '0);
`ifdef SEQ_INST_PREFETCH_EN
  assign w_idxPlus2 = r_idx + 2'd2;
  assign w_skipLast = (w_idxPlus2 == r_num);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state, instruction address and error-set decode
  always_comb begin
    w_nextState = r_state;
    w_setErr    = w_overflow;
    w_instAddr  = r_idx[INST_AW-1:0];
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = (inst_num != '0) ? FETCH : FINISH;
        end
      end
      FETCH: begin
        w_nextState = LATCH;
      end
      LATCH: begin
`ifdef SEQ_INST_PREFETCH_EN
        w_instAddr = w_idxPlus1[INST_AW-1:0];
`endif
        if (w_zeroLen) begin
          w_setErr = 1'b1;
`ifdef SEQ_INST_PREFETCH_EN
          w_nextState = w_lastInst ? DRAIN : LATCH;
`else
          w_nextState = w_lastInst ? DRAIN : FETCH;
`endif
        end else begin
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
`ifdef SEQ_INST_PREFETCH_EN
        w_instAddr = w_lastBeat ? w_idxPlus2[INST_AW-1:0] : w_idxPlus1[INST_AW-1:0];
        if (w_lastBeat) begin
          if (w_lastInst) begin
            w_nextState = DRAIN;
          end else if (w_zeroLen) begin
            w_setErr    = 1'b1;
            w_nextState = w_skipLast ? DRAIN : LATCH;
          end else begin
            w_nextState = ISSUE;
          end
        end
`else
        if (w_lastBeat) begin
          w_nextState = w_lastInst ? DRAIN : FETCH;
        end
`endif
      end
      DRAIN: begin
        if (w_resCount == r_expCnt) begin
          w_nextState = FINISH;
        end
      end
      FINISH: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Instruction walk, beat counting and the free-running read address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num     <= '0;
      r_idx     <= '0;
      r_expCnt  <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_memAddr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_num     <= inst_num;
            r_idx     <= '0;
            r_expCnt  <= '0;
            r_memAddr <= '0;
          end
        end
        LATCH: begin
          if (w_zeroLen) begin
            r_idx <= w_idxPlus1;
          end else begin
            r_len    <= inst_data;
            r_beat   <= '0;
            r_expCnt <= r_expCnt + 1'b1;
          end
        end
        ISSUE: begin
          r_memAddr <= r_memAddr + 1'b1;
          if (!w_lastBeat) begin
            r_beat <= r_beat + 1'b1;
          end else begin
`ifdef SEQ_INST_PREFETCH_EN
            if (!w_lastInst && w_zeroLen) begin
              r_idx <= w_idxPlus2;
            end else begin
              r_idx    <= w_idxPlus1;
              r_len    <= inst_data;
              r_beat   <= '0;
              r_expCnt <= w_lastInst ? r_expCnt : r_expCnt + 1'b1;
            end
`else
            r_idx <= w_idxPlus1;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky error, cleared by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_startAcc ? 1'b0 : r_err) | w_setErr;
    end
  end

  // Delay valid and framing by one cycle to line up with SRAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peVld <= 1'b0;
      r_peCtl <= 2'b00;
    end else begin
      r_peVld <= mem_rd;
      r_peCtl <= 2'b00;
      if (mem_rd) begin
        r_peCtl[CTL_LAST]  <= w_lastBeat;
        r_peCtl[CTL_FIRST] <= (r_beat == '0);
      end
    end
  end

  pe_result_collector #(
    .INST_AW (INST_AW),
    .RES_W   (RES_W)
  ) u_collector (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_startAcc),
    .i_active    (busy),
    .i_expected  (r_expCnt),
    .i_result    (pe_result),
    .i_resultVld (pe_vld_o),
    .o_resWr     (res_wr),
    .o_resAddr   (res_addr),
    .o_resData   (res_data),
    .o_count     (w_resCount),
    .o_overflow  (w_overflow)
  );

  assign inst_addr = w_instAddr;
  assign mem_rd    = (r_state == ISSUE);
  assign mem_addr  = r_memAddr;
  assign pe_neuron = neuron_i;
  assign pe_weight = weight_i;
  assign pe_vld    = r_peVld;
  assign pe_ctl    = r_peCtl;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FINISH);
  assign err       = r_err;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer with SRAM and parallel_pe models.
// Expectations adapt to SEQ_INST_PREFETCH_EN when it is defined.
module tb_pe_array_sequencer;

  localparam int INST_AW = 2;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 512;
  localparam int RES_W   = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [INST_AW:0]   inst_num = '0;
  logic [INST_AW-1:0] inst_addr;
  logic [7:0]         inst_data = '0;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  neuron_i = '0;
  logic [DATA_W-1:0]  weight_i = '0;
  logic [DATA_W-1:0]  pe_neuron;
  logic [DATA_W-1:0]  pe_weight;
  logic [1:0]         pe_ctl;
  logic               pe_vld;
  logic [RES_W-1:0]   pe_result;
  logic               pe_vld_o;
  logic               res_wr;
  logic [INST_AW-1:0] res_addr;
  logic [RES_W-1:0]   res_data;
  logic               busy;
  logic               done;
  logic               err;

  logic [7:0]  instMem [0:3];
  logic [31:0] peAcc;
  logic [31:0] peSum;

  int          assertCnt = 0;
  int          failCnt = 0;
  int          cyc = 0;
  logic [31:0] rdAddrQ[$];
  logic [31:0] ctlQ[$];
  logic [31:0] resAddrQ[$];
  logic [31:0] resDataQ[$];
  int          doneCnt;
  int          busyCnt;
  int          firstRd;
  int          lastRd;
  int          curRun;
  int          maxRun;

  pe_array_sequencer #(
    .INST_AW (INST_AW),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RES_W   (RES_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .inst_num  (inst_num),
    .inst_addr (inst_addr),
    .inst_data (inst_data),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .neuron_i  (neuron_i),
    .weight_i  (weight_i),
    .pe_neuron (pe_neuron),
    .pe_weight (pe_weight),
    .pe_ctl    (pe_ctl),
    .pe_vld    (pe_vld),
    .pe_result (pe_result),
    .pe_vld_o  (pe_vld_o),
    .res_wr    (res_wr),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Instruction SRAM with one-cycle read latency
  always @(posedge clk) inst_data <= instMem[inst_addr];

  // Neuron/weight SRAMs: neuron word = address, weight word = 2*address
  always @(posedge clk) begin
    if (mem_rd) begin
      neuron_i <= {{(DATA_W-ADDR_W){1'b0}}, mem_addr};
      weight_i <= {{(DATA_W-ADDR_W-1){1'b0}}, mem_addr, 1'b0};
    end
  end

  // parallel_pe model: sums low words over a frame, reports one cycle after the last beat
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_vld_o  <= 1'b0;
      pe_result <= '0;
      peAcc     <= '0;
    end else begin
      pe_vld_o <= 1'b0;
      if (pe_vld) begin
        peSum = (pe_ctl[0] ? 32'd0 : peAcc) + pe_neuron[31:0] + pe_weight[31:0];
        peAcc <= peSum;
        if (pe_ctl[1]) begin
          pe_vld_o  <= 1'b1;
          pe_result <= peSum;
        end
      end
    end
  end

  // Observe DUT outputs on the falling edge
  always @(negedge clk) begin
    if (mem_rd) begin
      rdAddrQ.push_back(32'(mem_addr));
      if (firstRd < 0) firstRd = cyc;
      lastRd = cyc;
    end
    if (pe_vld) begin
      ctlQ.push_back(32'(pe_ctl));
      curRun++;
      if (curRun > maxRun) maxRun = curRun;
    end else begin
      curRun = 0;
    end
    if (res_wr) begin
      resAddrQ.push_back(32'(res_addr));
      resDataQ.push_back(res_data);
    end
    if (done) doneCnt++;
    if (busy) busyCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCnt++;
    if (observed !== expected) begin
      failCnt++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearMonitors();
    rdAddrQ.delete();
    ctlQ.delete();
    resAddrQ.delete();
    resDataQ.delete();
    doneCnt = 0;
    busyCnt = 0;
    firstRd = -1;
    lastRd  = -1;
    curRun  = 0;
    maxRun  = 0;
  endtask

  task automatic loadInst(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    instMem[0] = a;
    instMem[1] = b;
    instMem[2] = c;
    instMem[3] = d;
  endtask

  task automatic applyStimulus(input int num);
    @(posedge clk);
    #1;
    inst_num = 3'(num);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (doneCnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (doneCnt == 0) checkOutput("doneTimeout", 32'd0, 32'd1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Checks for the {3,2,1,4} program
  task automatic checkProgram1(input string pfx);
    logic [31:0] expCtl [0:9];
    logic [31:0] expRes [0:3];
    expCtl = '{32'd1, 32'd0, 32'd2, 32'd1, 32'd2, 32'd3, 32'd1, 32'd0, 32'd0, 32'd2};
    expRes = '{32'd9, 32'd21, 32'd15, 32'd90};
    checkOutput({pfx, "_rdCount"}, 32'(rdAddrQ.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("%s_rdAddr%0d", pfx, i), (i < rdAddrQ.size()) ? rdAddrQ[i] : 32'hDEAD, 32'(i));
      checkOutput($sformatf("%s_ctl%0d", pfx, i), (i < ctlQ.size()) ? ctlQ[i] : 32'hDEAD, expCtl[i]);
    end
    checkOutput({pfx, "_resCount"}, 32'(resAddrQ.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s_resAddr%0d", pfx, i), (i < resAddrQ.size()) ? resAddrQ[i] : 32'hDEAD, 32'(i));
      checkOutput($sformatf("%s_resData%0d", pfx, i), (i < resDataQ.size()) ? resDataQ[i] : 32'hDEAD, expRes[i]);
    end
    checkOutput({pfx, "_doneCount"}, 32'(doneCnt), 32'd1);
    checkOutput({pfx, "_err"}, 32'(err), 32'd0);
    checkOutput({pfx, "_busyIdle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit found;
    clearMonitors();
    loadInst(8'd3, 8'd2, 8'd1, 8'd4);
    #12;
    // Reset state while rst_n is still low
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_memRd", 32'(mem_rd), 32'd0);
    checkOutput("rst_memAddr", 32'(mem_addr), 32'd0);
    checkOutput("rst_instAddr", 32'(inst_addr), 32'd0);
    checkOutput("rst_peVld", 32'(pe_vld), 32'd0);
    checkOutput("rst_resWr", 32'(res_wr), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Program {3,2,1,4}
    clearMonitors();
    applyStimulus(4);
    waitDone(200);
    checkProgram1("p1");
`ifdef SEQ_INST_PREFETCH_EN
    checkOutput("p1_rdSpan", 32'(lastRd - firstRd + 1), 32'd10);
    checkOutput("p1_vldRun", 32'(maxRun), 32'd10);
`else
    checkOutput("p1_rdSpan", 32'(lastRd - firstRd + 1), 32'd16);
    checkOutput("p1_vldRun", 32'(maxRun), 32'd4);
`endif

    // Program {2,0,2} with a zero-length instruction
    loadInst(8'd2, 8'd0, 8'd2, 8'd0);
    clearMonitors();
    applyStimulus(3);
    waitDone(200);
    checkOutput("p2_err", 32'(err), 32'd1);
    checkOutput("p2_rdCount", 32'(rdAddrQ.size()), 32'd4);
    checkOutput("p2_resCount", 32'(resAddrQ.size()), 32'd2);
    checkOutput("p2_resAddr0", (resAddrQ.size() > 0) ? resAddrQ[0] : 32'hDEAD, 32'd0);
    checkOutput("p2_resAddr1", (resAddrQ.size() > 1) ? resAddrQ[1] : 32'hDEAD, 32'd1);
    checkOutput("p2_resData0", (resDataQ.size() > 0) ? resDataQ[0] : 32'hDEAD, 32'd3);
    checkOutput("p2_resData1", (resDataQ.size() > 1) ? resDataQ[1] : 32'hDEAD, 32'd15);
    checkOutput("p2_doneCount", 32'(doneCnt), 32'd1);

    // Empty run: done the cycle after start, err cleared by start
    clearMonitors();
    applyStimulus(0);
    checkOutput("p0_doneNow", 32'(done), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("p0_doneCount", 32'(doneCnt), 32'd1);
    checkOutput("p0_busyCycles", 32'(busyCnt), 32'd1);
    checkOutput("p0_rdCount", 32'(rdAddrQ.size()), 32'd0);
    checkOutput("p0_err", 32'(err), 32'd0);

    // Second start during ISSUE is ignored
    loadInst(8'd3, 8'd2, 8'd1, 8'd4);
    clearMonitors();
    applyStimulus(4);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      found = mem_rd;
    end
    checkOutput("p3_issueSeen", 32'(found), 32'd1);
    inst_num = 3'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(200);
    checkProgram1("p3");

    // Asynchronous reset while instruction 1 issues, then a clean rerun
    clearMonitors();
    applyStimulus(4);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      found = mem_rd && (mem_addr == 16'd3);
    end
    checkOutput("p4_inst1Seen", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("p4_memRd", 32'(mem_rd), 32'd0);
    checkOutput("p4_memAddr", 32'(mem_addr), 32'd0);
    checkOutput("p4_busy", 32'(busy), 32'd0);
    checkOutput("p4_peVld", 32'(pe_vld), 32'd0);
    checkOutput("p4_peCtl", 32'(pe_ctl), 32'd0);
    checkOutput("p4_resWr", 32'(res_wr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clearMonitors();
    applyStimulus(4);
    waitDone(200);
    checkProgram1("p5");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
